// File: rtl/phase_run_ctrl.sv
// Run controller for the 3-phase FIRST/SECOND/THIRD FSM. It drives pause/restart to run a
// latched number of rounds, with a latched dwell per phase, and a host start/done/abort handshake.
module phase_run_ctrl #(
  parameter int unsigned RW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          hold_req_i,
  input  logic [RW-1:0] round_cnt_i,
  input  logic [DW-1:0] dwell_i,
  input  logic [1:0]    fsm_state_i,
  input  logic          fsm_terminal_i,
  output logic          fsm_pause_o,
  output logic          fsm_restart_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          aborted_o,
  output logic          err_o,
  output logic [RW-1:0] rounds_done_o
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [RW-1:0] rounds_done_q, rounds_done_d;
  logic [RW-1:0] rounds_inc;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          err_q, err_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      round_q       <= '0;
      dwell_q       <= '0;
      dwell_cnt_q   <= '0;
      rounds_done_q <= '0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      dwell_q       <= dwell_d;
      dwell_cnt_q   <= dwell_cnt_d;
      rounds_done_q <= rounds_done_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      err_q         <= err_d;
    end
  end

  assign rounds_inc = rounds_done_q + RW'(1);

  always_comb begin
    state_d       = state_q;
    round_d       = round_q;
    dwell_d       = dwell_q;
    dwell_cnt_d   = dwell_cnt_q;
    rounds_done_d = rounds_done_q;
    err_d         = err_q;
    done_d        = 1'b0;
    aborted_d     = 1'b0;
    fsm_pause_o   = 1'b0;
    fsm_restart_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Restart holds the phase FSM in FIRST until a run begins.
        fsm_restart_o = 1'b1;
        if (start_i) begin
          rounds_done_d = '0;
          err_d         = 1'b0;
          if (round_cnt_i != '0) begin
            state_d     = StRun;
            round_d     = round_cnt_i;
            dwell_d     = dwell_i;
            dwell_cnt_d = dwell_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        // Pause depends only on stall and dwell, so an abort cycle still shows the FSM's view.
        fsm_pause_o = hold_req_i || (dwell_cnt_q != '0);
        if (abort_i) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (fsm_state_i == 2'b00) begin
          state_d   = StIdle;
          err_d     = 1'b1;
          aborted_d = 1'b1;
        end else if (hold_req_i) begin
          dwell_cnt_d = dwell_cnt_q;
        end else if (dwell_cnt_q != '0) begin
          dwell_cnt_d = dwell_cnt_q - DW'(1);
        end else begin
          dwell_cnt_d = dwell_q;
          if (fsm_terminal_i) begin
            rounds_done_d = rounds_inc;
            if (rounds_inc == round_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o        = (state_q == StRun);
  assign done_o        = done_q;
  assign aborted_o     = aborted_q;
  assign err_o         = err_q;
  assign rounds_done_o = rounds_done_q;

endmodule

// File: tb/tb_phase_run_ctrl.sv
// Scoreboard bench for phase_run_ctrl: a driver predicts each run's outcome from round/phase
// arithmetic and queues it; a negedge monitor checks every done/aborted pulse against the queue.
module tb_phase_run_ctrl;
  localparam int RW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          hold_req = 1'b0;
  logic [RW-1:0] round_cnt = '0;
  logic [DW-1:0] dwell = '0;
  logic [1:0]    fsm_state;
  logic          fsm_terminal;
  logic          fsm_pause, fsm_restart, busy, done, aborted, err;
  logic [RW-1:0] rounds_done;

  always #5 clk = ~clk;

  phase_run_ctrl #(.RW(RW), .DW(DW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .abort_i        (abort),
    .hold_req_i     (hold_req),
    .round_cnt_i    (round_cnt),
    .dwell_i        (dwell),
    .fsm_state_i    (fsm_state),
    .fsm_terminal_i (fsm_terminal),
    .fsm_pause_o    (fsm_pause),
    .fsm_restart_o  (fsm_restart),
    .busy_o         (busy),
    .done_o         (done),
    .aborted_o      (aborted),
    .err_o          (err),
    .rounds_done_o  (rounds_done)
  );

  // Environment: the phase FSM being sequenced (11 -> 01 -> 10 -> 11), terminal in THIRD.
  logic [1:0] ph_q = 2'b11;
  bit         force_bad = 1'b0;
  always @(posedge clk) begin
    if (fsm_restart) ph_q <= 2'b11;
    else if (!fsm_pause) ph_q <= (ph_q == 2'b11) ? 2'b01 : (ph_q == 2'b01) ? 2'b10 : 2'b11;
  end
  assign fsm_state    = force_bad ? 2'b00 : ph_q;
  assign fsm_terminal = !force_bad && (ph_q == 2'b10);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int rounds;
    int at;
    bit err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Monitor: every completion pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (done || aborted) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse @cyc %0d: done=%0b aborted=%0b", cyc, done, aborted);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_cycle", cyc, e.at);
        check("done", done, e.is_done);
        check("aborted", aborted, !e.is_done);
        check("rounds_at_pulse", rounds_done, e.rounds);
        check("err_at_pulse", err, e.err);
      end
    end
  end

  // One host transaction. ab / bad: relative cycle of abort / illegal state (0 = never).
  task automatic run_txn(input int n, input int d, input int ab, input int bad, input bit use_hold);
    int   t, cnt, rounds, tot, period, c0;
    bit   h;
    bit   hold_arr[$];
    exp_t e;
    period = 3 * (d + 1);
    @(posedge clk); #1;
    c0        = cyc;
    start     = 1'b1;
    abort     = 1'b0;
    hold_req  = 1'b0;
    round_cnt = RW'(n);
    dwell     = DW'(d);
    e.err     = 1'b0;
    if (n == 0) begin
      e.is_done = 1'b1;
      e.rounds  = 0;
      tot       = 0;
    end else begin
      // A round ends on its (period*r)-th unstalled cycle; abort/illegal end the run first.
      hold_arr.push_back(1'b0);
      t = 0; cnt = 0; rounds = 0;
      forever begin
        t++;
        h = use_hold && ($urandom_range(0, 3) == 0);
        hold_arr.push_back(h);
        if (t == ab || t == bad) begin
          e.is_done = 1'b0;
          e.err     = (t != ab);
          break;
        end
        if (!h) begin
          cnt++;
          if (cnt % period == 0) begin
            rounds++;
            if (rounds == n) begin
              e.is_done = 1'b1;
              break;
            end
          end
        end
      end
      e.rounds = rounds;
      tot      = t;
    end
    e.at = c0 + tot + 1;
    sb_q.push_back(e);
    for (int k = 1; k <= tot; k++) begin
      @(posedge clk); #1;
      if (k == 1) check("busy_in_run", busy, 1);
      start     = ($urandom_range(0, 7) == 0);
      round_cnt = RW'($urandom);
      dwell     = DW'($urandom);
      abort     = (k == ab);
      force_bad = (k == bad);
      hold_req  = hold_arr[k];
    end
    @(posedge clk); #1;
    start     = 1'b0;
    abort     = 1'b0;
    hold_req  = 1'b0;
    force_bad = 1'b0;
    check("busy_after", busy, 0);
    check("rounds_after", rounds_done, e.rounds);
    for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
      @(posedge clk); #1;
      abort = ($urandom_range(0, 1) == 1);
    end
    abort = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_aborted"}, aborted, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_rounds"}, rounds_done, 0);
    check({tag, "_restart"}, fsm_restart, 1);
    check({tag, "_pause"}, fsm_pause, 0);
  endtask

  initial begin
    int n, d, ab;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    run_txn(2, 0, 0, 0, 1'b0);   // two rounds, no dwell
    run_txn(1, 1, 0, 0, 1'b0);   // dwell of one
    run_txn(1, 0, 0, 0, 1'b1);   // random stalls
    run_txn(3, 0, 6, 0, 1'b0);   // abort on the second terminal
    run_txn(0, 2, 0, 0, 1'b0);   // zero rounds
    run_txn(3, 0, 0, 2, 1'b0);   // illegal state
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", err, 1);
    run_txn(1, 0, 0, 0, 1'b0);   // start clears err
    run_txn(255, 0, 0, 0, 1'b0); // all-ones round count

    // Reset in the middle of a run.
    @(posedge clk); #1;
    start = 1'b1; round_cnt = 8'd5; dwell = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("busy_pre_reset", busy, 1);
    check("rounds_pre_reset", rounds_done, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_values("midrun_reset");
    repeat (2) @(posedge clk);

    for (int i = 0; i < 40; i++) begin
      n  = $urandom_range(0, 4);
      d  = $urandom_range(0, 3);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3 * n * (d + 1) + 2) : 0;
      run_txn(n, d, ab, 0, $urandom_range(0, 1) == 1);
    end

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
